// File: rtl/fib_hls_axis_stall_detector.sv
// Per-channel AXI-stream stall detector for the fib_fib_inst HLS instance.
// Flags channels stuck for STALL_THRESH consecutive cycles and captures the first one flagged.
module fib_hls_axis_stall_detector #(
   parameter int                  NUM_CHAN     = 4,
   parameter logic [NUM_CHAN-1:0] CHAN_DIR     = 4'b0011,
   parameter int                  STALL_THRESH = 16,
   parameter int                  CNT_W        = 8,
   parameter int                  IDX_W        = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_CHAN-1:0] axis_tvalid,
   input  logic [NUM_CHAN-1:0] axis_tready,
   input  logic                inst_idle,
   input  logic                clear_first,
   output logic [NUM_CHAN-1:0] axis_block_sigs,
   output logic                first_valid,
   output logic [IDX_W-1:0]    first_chan
);

   localparam logic [CNT_W-1:0] THR    = CNT_W'(STALL_THRESH);
   localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(STALL_THRESH - 1);

   logic [CNT_W-1:0]    r_cnt [NUM_CHAN];
   logic [CNT_W-1:0]    w_cnt_nxt [NUM_CHAN];
   logic [NUM_CHAN-1:0] w_stall;
   logic [NUM_CHAN-1:0] w_flag_nxt;
   logic [NUM_CHAN-1:0] r_flag;
   logic                r_first_valid;
   logic [IDX_W-1:0]    r_first_chan;

   // Lowest-index set bit; the loop runs high-to-low so the smallest index wins.
   function automatic logic [IDX_W-1:0] f_lowest_set(input logic [NUM_CHAN-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_CHAN - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Raw stall term: consumers wait on empty input, producers wait on full output.
   always_comb begin
      w_stall = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         if (CHAN_DIR[i]) begin
            w_stall[i] = axis_tready[i] & ~axis_tvalid[i] & ~inst_idle;
         end else begin
            w_stall[i] = axis_tvalid[i] & ~axis_tready[i] & ~inst_idle;
         end
      end
   end

   // Saturating counter next-state and block flag next-state per channel.
   always_comb begin
      w_flag_nxt = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         w_cnt_nxt[i] = '0;
         if (!w_stall[i]) begin
            w_cnt_nxt[i] = '0;
         end else if (r_cnt[i] >= THR) begin
            w_cnt_nxt[i] = THR;
         end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
         end
         w_flag_nxt[i] = w_stall[i] & (r_cnt[i] >= THR_M1);
      end
   end

   // Stall counters and registered block flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            r_cnt[i] <= '0;
         end
         r_flag <= '0;
      end else begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
         r_flag <= w_flag_nxt;
      end
   end

   // First-block capture; a clear on the same edge as a candidate wins and re-arms.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_first_valid <= 1'b0;
         r_first_chan  <= '0;
      end else if (clear_first) begin
         r_first_valid <= 1'b0;
         r_first_chan  <= '0;
      end else if (!r_first_valid && (|r_flag)) begin
         r_first_valid <= 1'b1;
         r_first_chan  <= f_lowest_set(r_flag);
      end else begin
         r_first_valid <= r_first_valid;
         r_first_chan  <= r_first_chan;
      end
   end

   assign axis_block_sigs = r_flag;
   assign first_valid     = r_first_valid;
   assign first_chan      = r_first_chan;

endmodule
